// File: rtl/store_merge_unit_pkg.sv
// Shared types for the store merge unit: opcodes, FSM states, store sizes.
package store_merge_unit_pkg;

   localparam logic [5:0] OPC_SB = 6'h28;
   localparam logic [5:0] OPC_SH = 6'h29;
   localparam logic [5:0] OPC_SW = 6'h2b;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_MERGE,
      S_WRITE,
      S_ERR
   } state_t;

   typedef enum logic [1:0] {
      SZ_B,
      SZ_H,
      SZ_W
   } size_t;

   function automatic size_t op_size(input logic [5:0] op);
      case (op)
         OPC_SB:  return SZ_B;
         OPC_SH:  return SZ_H;
         default: return SZ_W;
      endcase
   endfunction

   // Unsupported opcode or an address not aligned to the access size.
   function automatic logic store_err(input logic [5:0] op,
                                      input logic [1:0] lane);
      case (op)
         OPC_SB:  return 1'b0;
         OPC_SH:  return lane[0];
         OPC_SW:  return |lane;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] replicate(input logic [31:0] data,
                                             input size_t sz);
      case (sz)
         SZ_B:    return {4{data[7:0]}};
         SZ_H:    return {2{data[15:0]}};
         default: return data;
      endcase
   endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Little-endian lane merge: drops the narrowed store data into its lane(s)
// of an existing word, leaving the other lanes untouched.
module store_lane_merge
   import store_merge_unit_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] new_data,
   input  size_t       size,
   input  logic [1:0]  lane,
   output logic [31:0] merged
`ifdef STORE_BYTE_ENABLE_EN
   ,
   output logic [3:0]  byte_en
`endif
);

   always_comb begin
      merged = old_word;
      unique case (size)
         SZ_B: merged[{lane, 3'b000} +: 8] = new_data[7:0];
         SZ_H: begin
            if (lane[1]) merged[31:16] = new_data[15:0];
            else         merged[15:0]  = new_data[15:0];
         end
         default: merged = new_data;
      endcase
   end

`ifdef STORE_BYTE_ENABLE_EN
   always_comb begin
      byte_en = 4'hF;
      unique case (size)
         SZ_B:    byte_en = 4'b0001 << lane;
         SZ_H:    byte_en = lane[1] ? 4'b1100 : 4'b0011;
         default: byte_en = 4'hF;
      endcase
   end
`endif

endmodule

// File: rtl/store_merge_unit.sv
// sb/sh/sw store path with read-modify-write merge into a word memory.
// STORE_BYTE_ENABLE_EN: write with byte enables instead of RMW.
module store_merge_unit
   import store_merge_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_Start,
   input  logic [5:0]            i_Opcode,
   input  logic [31:0]           i_Address,
   input  logic [31:0]           i_WriteData,
   input  logic [31:0]           i_MemReadData,
   output logic [ADDR_WIDTH-1:0] o_MemAddress,
   output logic                  o_MemRead,
   output logic                  o_MemWrite,
   output logic [31:0]           o_MemWriteData,
   output logic                  o_Busy,
   output logic                  o_Done,
   output logic                  o_Error
`ifdef STORE_BYTE_ENABLE_EN
   ,
   output logic [3:0]            o_MemByteEnable
`endif
);

   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           word_q;
   logic [31:0]           merged;
   logic                  accept;
   logic                  bad;
   size_t                 size_in;
   logic                  unused_bits;

   assign accept  = (state == S_IDLE) & i_Start;
   assign size_in = op_size(i_Opcode);
   assign bad     = store_err(i_Opcode, i_Address[1:0]);

`ifdef STORE_BYTE_ENABLE_EN
   logic [3:0]  be_in, be_q;
   logic [31:0] rep;

   assign rep = replicate(i_WriteData, size_in);
   assign unused_bits = ^{i_Address[31:ADDR_WIDTH+2], i_MemReadData};

   // Replicated data merged into itself is the replicated word.
   store_lane_merge u_merge (
      .old_word (rep),
      .new_data (i_WriteData),
      .size     (size_in),
      .lane     (i_Address[1:0]),
      .merged   (merged),
      .byte_en  (be_in)
   );
`else
   logic [1:0]  lane_q;
   size_t       size_q;
   logic [31:0] data_q;

   assign unused_bits = ^i_Address[31:ADDR_WIDTH+2];

   store_lane_merge u_merge (
      .old_word (i_MemReadData),
      .new_data (data_q),
      .size     (size_q),
      .lane     (lane_q),
      .merged   (merged)
   );
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         addr_q <= '0;
         word_q <= '0;
`ifdef STORE_BYTE_ENABLE_EN
         be_q   <= '0;
`else
         lane_q <= '0;
         size_q <= SZ_B;
         data_q <= '0;
`endif
      end else begin
         state <= state_nx;
         if (accept) begin
            addr_q <= i_Address[ADDR_WIDTH+1:2];
`ifdef STORE_BYTE_ENABLE_EN
            word_q <= merged;
            be_q   <= be_in;
`else
            word_q <= i_WriteData;
            lane_q <= i_Address[1:0];
            size_q <= size_in;
            data_q <= i_WriteData;
`endif
         end else if (state == S_MERGE) begin
            word_q <= merged;
         end
      end
   end

   always_comb begin
      state_nx       = state;
      o_Busy         = (state != S_IDLE);
      o_MemRead      = (state == S_READ);
      o_MemWrite     = (state == S_WRITE);
      o_Done         = (state == S_WRITE) | (state == S_ERR);
      o_Error        = (state == S_ERR);
      o_MemAddress   = '0;
      o_MemWriteData = '0;
`ifdef STORE_BYTE_ENABLE_EN
      o_MemByteEnable = '0;
`endif
      if (state == S_READ || state == S_MERGE || state == S_WRITE)
         o_MemAddress = addr_q;
      if (state == S_WRITE) begin
         o_MemWriteData = word_q;
`ifdef STORE_BYTE_ENABLE_EN
         o_MemByteEnable = be_q;
`endif
      end
      unique case (state)
         S_IDLE: begin
            if (i_Start) begin
               if (bad)
                  state_nx = S_ERR;
`ifdef STORE_BYTE_ENABLE_EN
               else
                  state_nx = S_WRITE;
`else
               else if (size_in == SZ_W)
                  state_nx = S_WRITE;
               else
                  state_nx = S_READ;
`endif
            end
         end
         S_READ:  state_nx = S_MERGE;
         S_MERGE: state_nx = S_WRITE;
         S_WRITE: state_nx = S_IDLE;
         S_ERR:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_store_merge_unit.sv
// Scoreboard bench for store_merge_unit with a synchronous-read word memory.
`timescale 1ns/1ps
module tb_store_merge_unit;

   localparam logic [5:0] SB = 6'h28;
   localparam logic [5:0] SH = 6'h29;
   localparam logic [5:0] SW = 6'h2b;

   typedef struct {
      int          due;
      logic        err;
      logic [7:0]  addr;
      logic [31:0] word;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          reads;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [5:0]  opcode;
   logic [31:0] address;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic [7:0]  mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic        busy;
   logic        done;
   logic        error;
   logic [3:0]  be_w;
`ifdef STORE_BYTE_ENABLE_EN
   logic [3:0]  be;
   assign be_w = be;
`else
   assign be_w = 4'hF;
`endif

   logic [31:0] mem [256];
   logic        pre_en = 1'b0;
   logic [7:0]  pre_addr = '0;
   logic [31:0] pre_val = '0;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   rd_cnt = 0;
   int   done_cnt = 0;

   store_merge_unit #(.ADDR_WIDTH(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .i_Start        (start),
      .i_Opcode       (opcode),
      .i_Address      (address),
      .i_WriteData    (wr_data),
      .i_MemReadData  (rd_data),
      .o_MemAddress   (mem_addr),
      .o_MemRead      (mem_rd),
      .o_MemWrite     (mem_wr),
      .o_MemWriteData (mem_wdata),
      .o_Busy         (busy),
      .o_Done         (done),
      .o_Error        (error)
`ifdef STORE_BYTE_ENABLE_EN
      ,
      .o_MemByteEnable(be)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] apply(input logic [31:0] old,
                                         input logic [31:0] nw,
                                         input logic [3:0]  en);
      logic [31:0] r;
      r = old;
      for (int k = 0; k < 4; k++)
         if (en[k]) r[8*k +: 8] = nw[8*k +: 8];
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pre_en) mem[pre_addr] <= pre_val;
      if (mem_rd) rd_data <= mem[mem_addr];
      if (mem_wr) mem[mem_addr] <= apply(mem[mem_addr], mem_wdata, be_w);
   end

   always @(negedge clk) begin
      if (reset) begin
         exp_t e;
         if (mem_rd) begin
            rd_cnt++;
            if (q.size() != 0) check("rd_addr", 32'(mem_addr), 32'(q[0].addr));
         end
         if (mem_wr) check("wr_with_done", 32'(done), 32'd1);
         if (done) begin
            done_cnt++;
            if (q.size() == 0) begin
               check("spurious_done", 32'(q.size()), 32'd1);
            end else begin
               e = q.pop_front();
               check("latency", 32'(cyc), 32'(e.due));
               check("error", 32'(error), 32'(e.err));
               check("mem_write", 32'(mem_wr), 32'(!e.err));
               check("read_count", 32'(rd_cnt), 32'(e.reads));
               if (!e.err) begin
                  check("wr_addr", 32'(mem_addr), 32'(e.addr));
                  check("wdata", mem_wdata, e.wdata);
`ifdef STORE_BYTE_ENABLE_EN
                  check("byte_en", 32'(be), 32'(e.be));
                  check("mem_word", apply(mem[mem_addr], mem_wdata, be), e.word);
`endif
               end
            end
            rd_cnt = 0;
         end
      end
   end

   task automatic preload(input logic [7:0] a, input logic [31:0] v);
      @(negedge clk);
      pre_en = 1'b1; pre_addr = a; pre_val = v;
      @(negedge clk);
      pre_en = 1'b0;
   endtask

   task automatic issue(input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] word,
                        input logic [3:0] ben, input logic err,
                        input int extra);
      exp_t e;
      logic rmw;
      rmw = !err && (op != SW);
      e.err   = err;
      e.addr  = a[9:2];
      e.word  = word;
      e.be    = ben;
`ifdef STORE_BYTE_ENABLE_EN
      e.reads = 0;
      e.wdata = (op == SB) ? {4{d[7:0]}} : (op == SH) ? {2{d[15:0]}} : d;
`else
      e.reads = rmw ? 1 : 0;
      e.wdata = word;
`endif
      @(negedge clk);
      start = 1'b1; opcode = op; address = a; wr_data = d;
`ifdef STORE_BYTE_ENABLE_EN
      e.due = cyc + 1;
`else
      e.due = cyc + (rmw ? 3 : 1);
`endif
      q.push_back(e);
      for (int i = 0; i < extra; i++) begin
         @(negedge clk);
         opcode = SW; address = 32'h8; wr_data = 32'h1234_5678;
      end
      @(negedge clk);
      start = 1'b0; opcode = 6'h3f; address = 32'hFFFF_FFFF;
      wr_data = 32'h0BAD_0BAD;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (q.size() == 0) return;
      end
      check("timeout_pending", 32'(q.size()), 32'd0);
      q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int d0;
      reset = 1'b0; start = 1'b0; opcode = '0; address = '0; wr_data = '0;
      rd_data = '0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      #3;
      check("reset_ctrl", {27'd0, busy, done, error, mem_rd, mem_wr}, 32'd0);
      check("reset_wdata", mem_wdata, 32'd0);
      check("reset_addr", 32'(mem_addr), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      issue(SW, 32'h04, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'hF, 1'b0, 0);
      wait_idle();
      preload(8'd1, 32'h1122_3344);
      issue(SB, 32'h05, 32'hAABB_CCDD, 32'h1122_DD44, 4'b0010, 1'b0, 0);
      wait_idle();
      preload(8'd1, 32'h1122_3344);
      issue(SH, 32'h06, 32'h0000_BEEF, 32'hBEEF_3344, 4'b1100, 1'b0, 0);
      wait_idle();
      preload(8'd1, 32'h1122_3344);
      issue(SH, 32'h04, 32'h0000_BEEF, 32'h1122_BEEF, 4'b0011, 1'b0, 0);
      wait_idle();

      issue(SW, 32'h06, 32'h1111_1111, 32'h0, 4'h0, 1'b1, 0);
      wait_idle();
      issue(SH, 32'h05, 32'h2222_2222, 32'h0, 4'h0, 1'b1, 0);
      wait_idle();
      issue(6'h23, 32'h10, 32'h3333_3333, 32'h0, 4'h0, 1'b1, 0);
      wait_idle();

      preload(8'd1, 32'h1122_3344);
      issue(SB, 32'h07, 32'h0000_005A, 32'h5A22_3344, 4'b1000, 1'b0, 0);
      wait_idle();
      preload(8'd0, 32'hCAFE_F00D);
      issue(SB, 32'h00, 32'hFFFF_FF77, 32'hCAFE_F077, 4'b0001, 1'b0, 0);
      wait_idle();

      preload(8'd1, 32'h1122_3344);
      issue(SB, 32'h04, 32'h0000_0001, 32'h1122_3301, 4'b0001, 1'b0, 0);
      wait_idle();
      issue(SB, 32'h05, 32'h0000_0002, 32'h1122_0201, 4'b0010, 1'b0, 0);
      wait_idle();

      preload(8'd1, 32'h1122_3344);
      d0 = done_cnt;
      issue(SB, 32'h04, 32'h0000_0099, 32'h1122_3399, 4'b0001, 1'b0, 1);
      wait_idle();
      repeat (4) @(negedge clk);
      check("busy_ignored", 32'(done_cnt - d0), 32'd1);
      d0 = done_cnt;
      issue(SW, 32'h0C, 32'h7777_8888, 32'h7777_8888, 4'hF, 1'b0, 1);
      wait_idle();
      repeat (4) @(negedge clk);
      check("busy_ignored_sw", 32'(done_cnt - d0), 32'd1);

      preload(8'd1, 32'h1122_3344);
      issue(SB, 32'h05, 32'hAABB_CCDD, 32'h1122_DD44, 4'b0010, 1'b0, 0);
`ifndef STORE_BYTE_ENABLE_EN
      @(negedge clk);
`endif
      #2;
      check("busy_before_reset", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      check("async_reset", {29'd0, busy, mem_rd, mem_wr}, 32'd0);
      q.delete();
      rd_cnt = 0;
      repeat (2) @(negedge clk);
      check("abandoned_mem", mem[1], 32'h1122_3344);
      reset = 1'b1;
      issue(SW, 32'h0C, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 4'hF, 1'b0, 0);
      wait_idle();
      repeat (2) @(negedge clk);
      check("post_reset_mem", mem[3], 32'h0F0F_0F0F);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
